// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types, FSM encoding and saturation helpers for the band mixer
package eq_pkg;

    localparam int SMPL_W    = 16;
    localparam int VOL_W     = 12;
    localparam int VOL_SHIFT = 11;
    localparam int N_BANDS   = 5;

    typedef logic signed [SMPL_W-1:0] smpl_t;
    typedef logic [VOL_W-1:0]         vol_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        VOL   = 2'd2,
        OUT   = 2'd3
    } mix_state_t;

    localparam logic signed [31:0] SMPL_MAX = 32'sd32767;
    localparam logic signed [31:0] SMPL_MIN = -32'sd32768;

    // True when a wide signed value does not fit in a 16-bit sample.
    function automatic logic sat_clips(input logic signed [31:0] x);
        return (x > SMPL_MAX) || (x < SMPL_MIN);
    endfunction

    // Clamp a wide signed value to the 16-bit sample range.
    function automatic smpl_t sat16(input logic signed [31:0] x);
        if (x > SMPL_MAX) begin
            return 16'sh7FFF;
        end else if (x < SMPL_MIN) begin
            return 16'sh8000;
        end else begin
            return smpl_t'(x[15:0]);
        end
    endfunction

endpackage

// File: rtl/eq_vol_mult.sv
// rtl/eq_vol_mult.sv - registered volume multiply, arithmetic shift and saturate
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   en_i         load a new result this cycle
//   sum_i        saturated band sum (signed, W bits)
//   vol_i        volume pot (unsigned, VOL_W bits)
//   res_o        registered (sum * vol) >>> VOL_SHIFT, saturated to W bits
//   clip_o       registered flag: res_o was clamped (only with EQ_MIXER_CLIP_CNT_EN)
module eq_vol_mult
    import eq_pkg::*;
#(
    parameter int W         = 16,
    parameter int VOL_W     = 12,
    parameter int VOL_SHIFT = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic signed [W-1:0] sum_i,
    input  logic [VOL_W-1:0]    vol_i,
`ifdef EQ_MIXER_CLIP_CNT_EN
    output logic                clip_o,
`endif
    output logic signed [W-1:0] res_o
);

    localparam int P_W = W + VOL_W + 1;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;
    logic signed [31:0]    shifted_ext;
    logic signed [W-1:0]   res_q;

    // Zero-extending the volume keeps it non-negative in the signed product.
    assign prod        = sum_i * $signed({1'b0, vol_i});
    assign shifted     = prod >>> VOL_SHIFT;
    assign shifted_ext = {{(32-P_W){shifted[P_W-1]}}, shifted};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (en_i) begin
            res_q <= sat16(shifted_ext);
        end
    end

    assign res_o = res_q;

`ifdef EQ_MIXER_CLIP_CNT_EN
    logic clip_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_q <= 1'b0;
        end else if (en_i) begin
            clip_q <= sat_clips(shifted_ext);
        end
    end

    assign clip_o = clip_q;
`endif

endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - sequential five-band sum, volume scale and saturate for one channel
//
// Optional feature macro: EQ_MIXER_CLIP_CNT_EN (adds clip_clr input and clip_cnt output).
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   start                             one-cycle pulse, all band inputs valid
//   lp_scl/b1_scl/b2_scl/b3_scl/hp_scl scaled band samples (signed, W bits)
//   volume                            volume pot (unsigned, VOL_W bits)
//   aud_out                           mixed sample, held until next result
//   aud_vld                           one-cycle pulse when aud_out updates
//   busy                              high while a sample is in flight
//   ovr                               one-cycle pulse after a start arrived while busy
//   clip_clr / clip_cnt               clear / count of samples that clipped (optional)
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int W         = 16,
    parameter int VOL_W     = 12,
    parameter int VOL_SHIFT = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] lp_scl,
    input  logic signed [W-1:0] b1_scl,
    input  logic signed [W-1:0] b2_scl,
    input  logic signed [W-1:0] b3_scl,
    input  logic signed [W-1:0] hp_scl,
    input  logic [VOL_W-1:0]    volume,
`ifdef EQ_MIXER_CLIP_CNT_EN
    input  logic                clip_clr,
    output logic [15:0]         clip_cnt,
`endif
    output logic signed [W-1:0] aud_out,
    output logic                aud_vld,
    output logic                busy,
    output logic                ovr
);

    // Five W-bit values need three guard bits, so the accumulator never wraps.
    localparam int ACC_W = W + 3;

    mix_state_t state_q, state_d;

    logic [2:0]              idx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [W-1:0]     band_q [N_BANDS];
    logic [VOL_W-1:0]        vol_q;
    logic signed [W-1:0]     aud_out_q;
    logic                    aud_vld_q;
    logic                    ovr_q;

    logic signed [W-1:0]     band_sel;
    logic signed [ACC_W-1:0] band_ext;
    logic signed [31:0]      acc_ext;
    logic signed [W-1:0]     sat_sum;
    logic signed [W-1:0]     vol_res;

    assign busy = (state_q != IDLE);

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (idx_q == 3'd4) state_d = VOL;
            VOL:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        band_sel = '0;
        case (idx_q)
            3'd0:    band_sel = band_q[0];
            3'd1:    band_sel = band_q[1];
            3'd2:    band_sel = band_q[2];
            3'd3:    band_sel = band_q[3];
            3'd4:    band_sel = band_q[4];
            default: band_sel = '0;
        endcase
    end

    assign band_ext = {{(ACC_W-W){band_sel[W-1]}}, band_sel};
    assign acc_ext  = {{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign sat_sum  = sat16(acc_ext);

    // Datapath: capture, accumulate, publish
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            acc_q     <= '0;
            vol_q     <= '0;
            aud_out_q <= '0;
            aud_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < N_BANDS; i++) begin
                band_q[i] <= '0;
            end
        end else begin
            aud_vld_q <= (state_q == OUT);
            ovr_q     <= start && busy;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        band_q[0] <= lp_scl;
                        band_q[1] <= b1_scl;
                        band_q[2] <= b2_scl;
                        band_q[3] <= b3_scl;
                        band_q[4] <= hp_scl;
                        vol_q     <= volume;
                        acc_q     <= '0;
                        idx_q     <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + band_ext;
                    idx_q <= idx_q + 3'd1;
                end
                OUT: begin
                    aud_out_q <= vol_res;
                end
                default: ;
            endcase
        end
    end

    assign aud_out = aud_out_q;
    assign aud_vld = aud_vld_q;
    assign ovr     = ovr_q;

`ifdef EQ_MIXER_CLIP_CNT_EN
    logic        vol_clip;
    logic        sum_clip_q;
    logic [15:0] clip_cnt_q;
`endif

    eq_vol_mult #(
        .W         (W),
        .VOL_W     (VOL_W),
        .VOL_SHIFT (VOL_SHIFT)
    ) u_vol_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == VOL),
        .sum_i (sat_sum),
        .vol_i (vol_q),
`ifdef EQ_MIXER_CLIP_CNT_EN
        .clip_o(vol_clip),
`endif
        .res_o (vol_res)
    );

`ifdef EQ_MIXER_CLIP_CNT_EN
    // Count once per sample if either the sum or the post-volume value clipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_clip_q <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            if (state_q == VOL) begin
                sum_clip_q <= sat_clips(acc_ext);
            end
            if (clip_clr) begin
                clip_cnt_q <= '0;
            end else if ((state_q == OUT) && (sum_clip_q || vol_clip) &&
                         (clip_cnt_q != 16'hFFFF)) begin
                clip_cnt_q <= clip_cnt_q + 16'd1;
            end
        end
    end

    assign clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - directed self-checking bench for eq_band_mixer
module tb_eq_band_mixer;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] lp_scl, b1_scl, b2_scl, b3_scl, hp_scl;
    logic [11:0]        volume;
    logic signed [15:0] aud_out;
    logic               aud_vld;
    logic               busy;
    logic               ovr;
`ifdef EQ_MIXER_CLIP_CNT_EN
    logic               clip_clr;
    logic [15:0]        clip_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int          r_lat;
    int          r_vcnt;
    int          r_ocnt;
    logic [15:0] r_out;
    logic        r_busy1;
    logic        r_busy7;

    eq_band_mixer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .lp_scl   (lp_scl),
        .b1_scl   (b1_scl),
        .b2_scl   (b2_scl),
        .b3_scl   (b3_scl),
        .hp_scl   (hp_scl),
        .volume   (volume),
`ifdef EQ_MIXER_CLIP_CNT_EN
        .clip_clr (clip_clr),
        .clip_cnt (clip_cnt),
`endif
        .aud_out  (aud_out),
        .aud_vld  (aud_vld),
        .busy     (busy),
        .ovr      (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic set_bands(input logic [15:0] lp, input logic [15:0] b1, input logic [15:0] b2,
                             input logic [15:0] b3, input logic [15:0] hp, input logic [11:0] vol);
        lp_scl = lp; b1_scl = b1; b2_scl = b2; b3_scl = b3; hp_scl = hp; volume = vol;
    endtask

    // Pulse start with the given bands; optionally pulse a second start so it is
    // sampled p2 edges later, and optionally scramble inputs right after start.
    task automatic run_sample(input logic [15:0] lp, input logic [15:0] b1, input logic [15:0] b2,
                              input logic [15:0] b3, input logic [15:0] hp, input logic [11:0] vol,
                              input int p2, input bit scramble);
        @(negedge clk);
        set_bands(lp, b1, b2, b3, hp, vol);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) set_bands(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 12'h000);
        r_lat = -1; r_vcnt = 0; r_ocnt = 0; r_out = 16'hxxxx; r_busy1 = 1'b0; r_busy7 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) r_busy1 = busy;
            if (k == 7) r_busy7 = busy;
            if (aud_vld) begin
                r_vcnt++;
                if (r_lat < 0) begin
                    r_lat = k;
                    r_out = aud_out;
                end
            end
            if (ovr) r_ocnt++;
            start = (k + 1 == p2);
            if (start) set_bands(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 12'hFFF);
        end
        start = 1'b0;
    endtask

    initial begin
        int vcnt;
        rst_n = 1'b0;
        start = 1'b0;
        set_bands(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 12'h0);
`ifdef EQ_MIXER_CLIP_CNT_EN
        clip_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_aud_out", 32'(aud_out), 32'h0);
        chk("rst_aud_vld", 32'(aud_vld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        rst_n = 1'b1;

        run_sample(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 12'h800, 0, 1'b0);
        chk("unity_out", 32'(r_out), 32'h0500);
        chk("unity_lat", 32'(r_lat), 32'd7);
        chk("unity_vcnt", 32'(r_vcnt), 32'd1);
        chk("unity_busy1", 32'(r_busy1), 32'h1);
        chk("unity_busy7", 32'(r_busy7), 32'h0);
        chk("unity_ovr", 32'(r_ocnt), 32'd0);

        run_sample(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 12'h800, 0, 1'b0);
        chk("pos_clip_out", 32'(r_out), 32'h7FFF);
`ifdef EQ_MIXER_CLIP_CNT_EN
        chk("clip_cnt_1", 32'(clip_cnt), 32'd1);
`endif

        run_sample(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 12'h800, 0, 1'b0);
        chk("neg_clip_out", 32'(r_out), 32'h8000);
`ifdef EQ_MIXER_CLIP_CNT_EN
        chk("clip_cnt_2", 32'(clip_cnt), 32'd2);
`endif

        run_sample(16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'hFFF, 0, 1'b0);
        chk("vol_max_out", 32'(r_out), 32'h3FFC);
`ifdef EQ_MIXER_CLIP_CNT_EN
        chk("clip_cnt_noclip", 32'(clip_cnt), 32'd2);
`endif

        run_sample(16'h6000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'hFFF, 0, 1'b0);
        chk("vol_clip_out", 32'(r_out), 32'h7FFF);
`ifdef EQ_MIXER_CLIP_CNT_EN
        chk("clip_cnt_3", 32'(clip_cnt), 32'd3);
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        chk("clip_cnt_clr", 32'(clip_cnt), 32'd0);
`endif

        run_sample(16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h000, 0, 1'b0);
        chk("vol_zero_out", 32'(r_out), 32'h0000);

        run_sample(16'hFF00, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 12'h800, 0, 1'b0);
        chk("neg_sum_out", 32'(r_out), 32'hFE00);

        run_sample(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 12'h800, 3, 1'b0);
        chk("ovr3_out", 32'(r_out), 32'h00F0);
        chk("ovr3_vcnt", 32'(r_vcnt), 32'd1);
        chk("ovr3_ocnt", 32'(r_ocnt), 32'd1);
        chk("ovr3_lat", 32'(r_lat), 32'd7);

        run_sample(16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h400, 7, 1'b0);
        chk("ovr7_out", 32'(r_out), 32'h0200);
        chk("ovr7_vcnt", 32'(r_vcnt), 32'd1);
        chk("ovr7_ocnt", 32'(r_ocnt), 32'd1);

        run_sample(16'h0123, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 12'h800, 0, 1'b1);
        chk("capture_out", 32'(r_out), 32'h01CD);

        // Reset while accumulating.
        @(negedge clk);
        set_bands(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 12'h800);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_aud_out", 32'(aud_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (aud_vld) vcnt++;
            @(negedge clk);
        end
        chk("abort_vcnt", 32'(vcnt), 32'd0);

        run_sample(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 12'h800, 0, 1'b0);
        chk("post_abort_out", 32'(r_out), 32'h0500);
        chk("post_abort_lat", 32'(r_lat), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
